grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
//  Shares the single GRF write port between the pipeline W stage (port P) and a
//  multi-cycle execution unit (port M, e.g. mul/div writeback). Holds a 32-entry
//  busy scoreboard of registers with outstanding M writes for the hazard unit.
//  Sits between the W stage / M unit and the GRF write inputs (WE, A3, WD, PC_W).
// PARAMETERS
//  STARVE_LIMIT  4   cycles M may lose arbitration before it is force-granted (>=1)
//  ADDR_W        5   register address width (32 registers, $0 hardwired zero)
//  DATA_W        32  write data / PC width
// PORTS
//  clk           in   1       system clock, all state on posedge
//  reset         in   1       asynchronous, active-high; clears all state
//  p_we          in   1       W-stage write request (cannot be back-pressured except via p_stall)
//  p_addr        in   ADDR_W  W-stage destination
//  p_wd          in   DATA_W  W-stage data
//  p_pc          in   DATA_W  W-stage PC (for write trace)
//  p_stall       out  1       1 = W stage must hold its instruction this cycle
//  m_issue       in   1       M unit accepted an op that will write m_issue_addr
//  m_issue_addr  in   ADDR_W  reserved destination
//  m_valid       in   1       M result ready to write
//  m_addr        in   ADDR_W  M destination
//  m_wd          in   DATA_W  M data
//  m_pc          in   DATA_W  M PC
//  m_ready       out  1       M write accepted this cycle (transfer = m_valid & m_ready)
//  q_a1, q_a2    in   ADDR_W  hazard-unit source queries (rs, rt)
//  q_busy1/2     out  1       query register has an outstanding M write
//  sb_conflict   out  1       sticky: m_issue to an already-busy register
//  grf_we        out  1       to GRF WE
//  grf_a3        out  ADDR_W  to GRF A3
//  grf_wd        out  DATA_W  to GRF WD
//  grf_pc        out  DATA_W  to GRF PC_W
// BEHAVIOUR
//  - Outputs combinational from inputs + registered state; zero write latency.
//  - Reset (async assert, sync-safe deassert): busy=0, wait_cnt=0, state=IDLE,
//    sb_conflict=0; while reset=1 grf_we=0, m_ready=0, p_stall=0, q_busy*=0.
//  - p_req = p_we & (p_addr!=0); p_we to $0 consumes no port cycle.
//  - FSM IDLE: p_req wins; m_ready = m_valid & ~p_req. If m_valid & p_req ->
//    WAIT, wait_cnt=1.
//  - WAIT: p_req still wins, wait_cnt++ each losing cycle; M granted alone ->
//    IDLE, wait_cnt=0. When wait_cnt==STARVE_LIMIT -> FORCE.
//  - FORCE: m_ready=1, p_stall=p_req, grf_* driven from M; on transfer -> IDLE,
//    wait_cnt=0. m_valid dropping in WAIT/FORCE -> IDLE, wait_cnt=0.
//  - Grant mux: grant P -> grf_* = p_*; grant M -> grf_* = m_*; none -> grf_we=0
//    (a3/wd/pc hold don't-care, drive 0).
//  - M transfer with m_addr==0: accepted, grf_we=0.
//  - Scoreboard: m_issue & m_issue_addr!=0 sets busy[addr]; M transfer clears
//    busy[m_addr]. Same cycle, same addr: set wins. Issue to busy reg -> busy
//    stays 1, sb_conflict set until reset.
//  - q_busyN = busy[q_aN] & q_aN!=0 & ~(M transfer this cycle & m_addr==q_aN):
//    retiring value reaches readers via GRF write bypass in the same cycle.
//  - Bit 0 of busy never set. Mid-operation reset discards pending M grants.
// STRUCTURE
//  - Shared package/header: ADDR_W, DATA_W, REG_ZERO=5'd0, FSM state encodings
//    (IDLE=2'd0, WAIT=2'd1, FORCE=2'd2).
//  - Sub-module grf_scoreboard: busy vector, set/clear/conflict, two query ports.
//  - Top: arbitration FSM, wait counter ($clog2(STARVE_LIMIT+1) bits), grant mux.
// TESTING
//  1 p_we=1,p_addr=8,p_wd=0x11; m idle -> grf_we=1,a3=8,wd=0x11,p_stall=0.
//  2 m_valid=1,m_addr=9 with p_req every cycle, STARVE_LIMIT=4 -> m_ready=0 for 4
//    cycles, 5th cycle m_ready=1,p_stall=1,grf_a3=9; next cycle P wins again.
//  3 m_issue addr 5; q_a1=5 -> q_busy1=1; M transfer addr 5 -> q_busy1=0 same
//    cycle, busy cleared next cycle.
//  4 m_issue addr 7 twice -> sb_conflict=1 sticky; issue+retire addr 7 same cycle
//    -> busy[7] stays 1.
//  5 p_we=1,p_addr=0 with m_valid=1 -> m_ready=1, M written, no wait_cnt increment.
//  6 reset asserted mid-WAIT (async, off clock edge) -> outputs 0 immediately,
//    all busy=0, state IDLE after release.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter slice.
//  ADDR_W / DATA_W : register address and data/PC widths
//  NUM_REGS        : number of architectural registers
//  REG_ZERO        : hardwired-zero register address
//  arb_state_e     : arbitration FSM state encodings
package grf_wb_arbiter_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the W stage / M unit / hazard unit and the GRF write port.
//  slave  : arbiter side (takes requests and queries, drives grants, GRF write, busy flags)
//  master : environment side (W stage, M unit, hazard unit, GRF)
interface grf_wb_arbiter_if;
  import grf_wb_arbiter_pkg::*;

  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wd;
  logic [DATA_W-1:0] p_pc;
  logic              p_stall;
  logic              m_issue;
  logic [ADDR_W-1:0] m_issue_addr;
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;
  logic [DATA_W-1:0] m_pc;
  logic              m_ready;
  logic [ADDR_W-1:0] q_a1;
  logic [ADDR_W-1:0] q_a2;
  logic              q_busy1;
  logic              q_busy2;
  logic              sb_conflict;
  logic              grf_we;
  logic [ADDR_W-1:0] grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] grf_pc;

  modport slave (
    input  p_we, p_addr, p_wd, p_pc, m_issue, m_issue_addr,
    input  m_valid, m_addr, m_wd, m_pc, q_a1, q_a2,
    output p_stall, m_ready, q_busy1, q_busy2, sb_conflict,
    output grf_we, grf_a3, grf_wd, grf_pc
  );

  modport master (
    output p_we, p_addr, p_wd, p_pc, m_issue, m_issue_addr,
    output m_valid, m_addr, m_wd, m_pc, q_a1, q_a2,
    input  p_stall, m_ready, q_busy1, q_busy2, sb_conflict,
    input  grf_we, grf_a3, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wb_arbiter_scoreboard.sv
// Busy scoreboard of registers with an outstanding M-unit write.
//  clk, reset          : clock, async active-high reset
//  set_en / set_addr   : M issue reserving a destination
//  clr_en / clr_addr   : M writeback transfer retiring a destination
//  q_a1/q_a2           : source queries; q_busy1/q_busy2 the answers
//  conflict            : sticky flag, issue to an already-busy register
module grf_scoreboard
  import grf_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              conflict
);
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] set_vec_s;
  logic [NUM_REGS-1:0] clr_vec_s;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                set_s;
  logic                conflict_r;

  // Decode set/clear one-hots; set applied after clear so a same-cycle issue wins.
  always_comb begin
    set_vec_s = '0;
    clr_vec_s = '0;
    set_s     = set_en && (set_addr != REG_ZERO);
    if (set_s) begin
      set_vec_s[set_addr] = 1'b1;
    end else begin
      set_vec_s = '0;
    end
    if (clr_en) begin
      clr_vec_s[clr_addr] = 1'b1;
    end else begin
      clr_vec_s = '0;
    end
    busy_next_s    = (busy_r & ~clr_vec_s) | set_vec_s;
    busy_next_s[0] = 1'b0;
  end

  // Busy vector and sticky conflict flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r     <= '0;
      conflict_r <= 1'b0;
    end else begin
      busy_r     <= busy_next_s;
      conflict_r <= conflict_r | (set_s & busy_r[set_addr]);
    end
  end

  // A register retiring this cycle reads as free: the GRF bypasses the write.
  always_comb begin
    q_busy1 = busy_r[q_a1] && (q_a1 != REG_ZERO) && !(clr_en && (clr_addr == q_a1));
    q_busy2 = busy_r[q_a2] && (q_a2 != REG_ZERO) && !(clr_en && (clr_addr == q_a2));
  end

  assign conflict = conflict_r;
endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W stage (P) and a
// multi-cycle execution unit (M), with starvation protection for M.
//  clk, reset : clock, async active-high reset
//  bus        : request/grant, GRF write and scoreboard query signals
//  STARVE_LIMIT : losing cycles tolerated before M is force-granted (>=1)
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  grf_wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_e        state_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              p_req_s;
  logic              m_ready_s;
  logic              p_stall_s;
  logic              grant_m_s;
  logic              grant_p_s;

  // Request qualification, M ready / P stall per state, and grant decode.
  always_comb begin
    p_req_s   = bus.p_we && (bus.p_addr != REG_ZERO);
    m_ready_s = 1'b0;
    p_stall_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_WAIT: begin
        m_ready_s = bus.m_valid && !p_req_s;
        p_stall_s = 1'b0;
      end
      ST_FORCE: begin
        m_ready_s = 1'b1;
        p_stall_s = p_req_s;
      end
      default: begin
        m_ready_s = 1'b0;
        p_stall_s = 1'b0;
      end
    endcase
    if (reset) begin
      m_ready_s = 1'b0;
      p_stall_s = 1'b0;
    end else begin
      m_ready_s = m_ready_s;
      p_stall_s = p_stall_s;
    end
    grant_m_s = bus.m_valid && m_ready_s;
    grant_p_s = p_req_s && !grant_m_s && !p_stall_s && !reset;
  end

  // GRF write mux; an M retire to $0 is accepted but never written.
  always_comb begin
    if (grant_m_s) begin
      bus.grf_we = (bus.m_addr != REG_ZERO);
      bus.grf_a3 = bus.m_addr;
      bus.grf_wd = bus.m_wd;
      bus.grf_pc = bus.m_pc;
    end else if (grant_p_s) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = bus.p_addr;
      bus.grf_wd = bus.p_wd;
      bus.grf_pc = bus.p_pc;
    end else begin
      bus.grf_we = 1'b0;
      bus.grf_a3 = REG_ZERO;
      bus.grf_wd = 32'd0;
      bus.grf_pc = 32'd0;
    end
  end

  // Arbitration FSM and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.m_valid && p_req_s) begin
            wait_cnt_r <= CNT_ONE;
            state_r    <= (CNT_ONE == CNT_LIMIT) ? ST_FORCE : ST_WAIT;
          end else begin
            wait_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!bus.m_valid || !p_req_s) begin
            // M withdrew, or M was granted alone this cycle.
            wait_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
            state_r    <= ((wait_cnt_r + CNT_ONE) == CNT_LIMIT) ? ST_FORCE : ST_WAIT;
          end
        end
        ST_FORCE: begin
          // m_ready is 1 here, so M either transfers or has dropped valid.
          wait_cnt_r <= '0;
          state_r    <= ST_IDLE;
        end
        default: begin
          wait_cnt_r <= '0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  grf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.m_issue),
    .set_addr (bus.m_issue_addr),
    .clr_en   (grant_m_s),
    .clr_addr (bus.m_addr),
    .q_a1     (bus.q_a1),
    .q_a2     (bus.q_a2),
    .q_busy1  (bus.q_busy1),
    .q_busy2  (bus.q_busy2),
    .conflict (bus.sb_conflict)
  );

  assign bus.m_ready = m_ready_s;
  assign bus.p_stall = p_stall_s;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter (STARVE_LIMIT = 4).
module tb_grf_wb_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  grf_wb_arbiter_if bus ();

  grf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_we = 1'b0; bus.p_addr = 5'd0; bus.p_wd = 32'd0; bus.p_pc = 32'd0;
    bus.m_issue = 1'b0; bus.m_issue_addr = 5'd0;
    bus.m_valid = 1'b0; bus.m_addr = 5'd0; bus.m_wd = 32'd0; bus.m_pc = 32'd0;
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    idle_inputs();
    bus.q_a1 = 5'd0; bus.q_a2 = 5'd0;
    // Requests present during reset must not produce a write or grant.
    bus.p_we = 1'b1; bus.p_addr = 5'd8; bus.m_valid = 1'b1; bus.m_addr = 5'd9;
    #2;
    chk("rst_grf_we", bus.grf_we, 32'd0);
    chk("rst_m_ready", bus.m_ready, 32'd0);
    chk("rst_p_stall", bus.p_stall, 32'd0);
    chk("rst_conflict", bus.sb_conflict, 32'd0);
    tick(); tick();
    reset = 1'b0;
    idle_inputs();

    // 1: P write alone.
    bus.p_we = 1'b1; bus.p_addr = 5'd8; bus.p_wd = 32'h11; bus.p_pc = 32'h100;
    #2;
    chk("t1_we", bus.grf_we, 32'd1);
    chk("t1_a3", bus.grf_a3, 32'd8);
    chk("t1_wd", bus.grf_wd, 32'h11);
    chk("t1_pc", bus.grf_pc, 32'h100);
    chk("t1_stall", bus.p_stall, 32'd0);
    chk("t1_mready", bus.m_ready, 32'd0);
    tick();

    // 2: M starves 4 cycles, forced on the 5th, then P wins again.
    bus.p_addr = 5'd10; bus.p_wd = 32'h22;
    bus.m_valid = 1'b1; bus.m_addr = 5'd9; bus.m_wd = 32'h99; bus.m_pc = 32'h200;
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk($sformatf("t2_lose%0d_mready", i), bus.m_ready, 32'd0);
      chk($sformatf("t2_lose%0d_a3", i), bus.grf_a3, 32'd10);
      chk($sformatf("t2_lose%0d_stall", i), bus.p_stall, 32'd0);
      tick();
    end
    #2;
    chk("t2_force_mready", bus.m_ready, 32'd1);
    chk("t2_force_stall", bus.p_stall, 32'd1);
    chk("t2_force_a3", bus.grf_a3, 32'd9);
    chk("t2_force_wd", bus.grf_wd, 32'h99);
    chk("t2_force_pc", bus.grf_pc, 32'h200);
    chk("t2_force_we", bus.grf_we, 32'd1);
    tick();
    #2;
    chk("t2_after_mready", bus.m_ready, 32'd0);
    chk("t2_after_a3", bus.grf_a3, 32'd10);
    chk("t2_after_stall", bus.p_stall, 32'd0);
    tick();
    // Now in WAIT; M granted alone when P goes quiet.
    bus.p_we = 1'b0;
    #2;
    chk("t2_alone_mready", bus.m_ready, 32'd1);
    chk("t2_alone_a3", bus.grf_a3, 32'd9);
    chk("t2_alone_we", bus.grf_we, 32'd1);
    tick();
    idle_inputs();
    #2;
    chk("t2_none_we", bus.grf_we, 32'd0);
    chk("t2_none_a3", bus.grf_a3, 32'd0);

    // 3: scoreboard set, same-cycle bypass on retire, clear.
    bus.m_issue = 1'b1; bus.m_issue_addr = 5'd5; bus.q_a1 = 5'd5; bus.q_a2 = 5'd6;
    #1;
    chk("t3_pre_busy1", bus.q_busy1, 32'd0);
    tick();
    bus.m_issue = 1'b0;
    #2;
    chk("t3_busy1", bus.q_busy1, 32'd1);
    chk("t3_busy2", bus.q_busy2, 32'd0);
    tick();
    bus.m_valid = 1'b1; bus.m_addr = 5'd5; bus.m_wd = 32'h55aa;
    #2;
    chk("t3_retire_busy1", bus.q_busy1, 32'd0);
    chk("t3_retire_mready", bus.m_ready, 32'd1);
    chk("t3_retire_a3", bus.grf_a3, 32'd5);
    tick();
    bus.m_valid = 1'b0;
    #2;
    chk("t3_cleared_busy1", bus.q_busy1, 32'd0);
    chk("t3_conflict", bus.sb_conflict, 32'd0);

    // 4: double issue -> sticky conflict; issue+retire same cycle keeps busy.
    bus.m_issue = 1'b1; bus.m_issue_addr = 5'd7; bus.q_a1 = 5'd7;
    tick();
    #1;
    chk("t4_first_conflict", bus.sb_conflict, 32'd0);
    tick();
    bus.m_issue = 1'b0;
    #2;
    chk("t4_conflict", bus.sb_conflict, 32'd1);
    chk("t4_busy1", bus.q_busy1, 32'd1);
    bus.m_issue = 1'b1; bus.m_valid = 1'b1; bus.m_addr = 5'd7;
    #1;
    chk("t4_same_busy1", bus.q_busy1, 32'd0);
    tick();
    idle_inputs();
    #2;
    chk("t4_set_wins", bus.q_busy1, 32'd1);
    chk("t4_sticky", bus.sb_conflict, 32'd1);

    // 5: P write to $0 takes no port cycle.
    bus.p_we = 1'b1; bus.p_addr = 5'd0; bus.p_wd = 32'hdead;
    bus.m_valid = 1'b1; bus.m_addr = 5'd12; bus.m_wd = 32'h5555;
    #1;
    chk("t5_mready", bus.m_ready, 32'd1);
    chk("t5_we", bus.grf_we, 32'd1);
    chk("t5_a3", bus.grf_a3, 32'd12);
    chk("t5_wd", bus.grf_wd, 32'h5555);
    chk("t5_stall", bus.p_stall, 32'd0);
    tick();
    // Counter untouched: a fresh contention still needs the full 4 losses.
    bus.p_addr = 5'd3; bus.p_wd = 32'h33;
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk($sformatf("t5_lose%0d_mready", i), bus.m_ready, 32'd0);
      tick();
    end
    #2;
    chk("t5_force_mready", bus.m_ready, 32'd1);
    tick();

    // 6: async reset mid-WAIT.
    for (int i = 1; i <= 2; i++) begin
      #2;
      chk($sformatf("t6_lose%0d_mready", i), bus.m_ready, 32'd0);
      tick();
    end
    #2;
    chk("t6_pre_busy1", bus.q_busy1, 32'd1);
    chk("t6_pre_we", bus.grf_we, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_we", bus.grf_we, 32'd0);
    chk("t6_rst_mready", bus.m_ready, 32'd0);
    chk("t6_rst_stall", bus.p_stall, 32'd0);
    chk("t6_rst_busy1", bus.q_busy1, 32'd0);
    chk("t6_rst_conflict", bus.sb_conflict, 32'd0);
    tick();
    reset = 1'b0;
    // Contention restarts from IDLE: 4 losses then force.
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk($sformatf("t6_post_lose%0d_mready", i), bus.m_ready, 32'd0);
      chk($sformatf("t6_post_lose%0d_busy1", i), bus.q_busy1, 32'd0);
      tick();
    end
    #2;
    chk("t6_post_force_mready", bus.m_ready, 32'd1);
    chk("t6_post_force_a3", bus.grf_a3, 32'd12);
    tick();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
